spi_cmd_ctrl: RTL and testbench

//  Command processor behind the SPI slave in the ov7670 design. Consumes 32-bit host commands
//  (byte2|byte1|byte0|opcode), performs register writes toward the SCCB master, and reads 32-byte

---
 rtl/spi_cmd_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_spi_cmd_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_ctrl.sv
// Command processor behind the SPI slave: decodes 32-bit host commands, drives SCCB register
// writes, and packs 32-byte frame-buffer reads into one 256-bit reply word.
module spi_cmd_ctrl #(
    parameter int         ADDR_W       = 17,
    parameter logic [7:0] STATUS_MAGIC = 8'h5A
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [31:0]       cmd_data,
    output logic              cmd_ack,
    input  logic              tx_free,
    output logic              tx_en,
    output logic [255:0]      tx_data,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    input  logic              reg_busy,
    output logic              reg_req,
    output logic [7:0]        reg_addr,
    output logic [7:0]        reg_val,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DECODE   = 3'd1,
        S_FETCH    = 3'd2,
        S_TX_WAIT  = 3'd3,
        S_REG_WAIT = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         cmd_q, cmd_d;
    logic                cmd_seen_q, cmd_seen_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          err_cnt_q, err_cnt_d;
    logic [5:0]          issue_k_q, issue_k_d;
    logic [4:0]          cap_k_q, cap_k_d;
    logic                rd_pend_q, rd_pend_d;
    logic                cmd_ack_q, cmd_ack_d;
    logic                tx_en_q, tx_en_d;
    logic [255:0]        tx_data_q, tx_data_d;
    logic                mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                reg_req_q, reg_req_d;
    logic [7:0]          reg_addr_q, reg_addr_d;
    logic [7:0]          reg_val_q, reg_val_d;

    // Handshakes: cmd_ack, tx_en and reg_req are single-cycle pulses; a command is consumed
    // only from IDLE, and cmd_seen blocks re-consuming it until the slave drops cmd_valid.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        cmd_seen_d  = cmd_valid ? cmd_seen_q : 1'b0;
        addr_d      = addr_q;
        err_cnt_d   = err_cnt_q;
        issue_k_d   = issue_k_q;
        cap_k_d     = cap_k_q;
        rd_pend_d   = 1'b0;
        cmd_ack_d   = 1'b0;
        tx_en_d     = 1'b0;
        tx_data_d   = tx_data_q;
        mem_rd_en_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        reg_req_d   = 1'b0;
        reg_addr_d  = reg_addr_q;
        reg_val_d   = reg_val_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && !cmd_seen_q) begin
                    cmd_ack_d  = 1'b1;
                    cmd_d      = cmd_data;
                    cmd_seen_d = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_IDLE;
                case (cmd_q[7:0])
                    8'h00, 8'h01: state_d = S_IDLE;
                    8'h10: addr_d = ADDR_W'(cmd_q[31:8]);
                    8'h11: begin
                        issue_k_d = 6'd0;
                        cap_k_d   = 5'd0;
                        state_d   = S_FETCH;
                    end
                    8'h20: begin
                        reg_addr_d = cmd_q[15:8];
                        reg_val_d  = cmd_q[23:16];
                        state_d    = S_REG_WAIT;
                    end
                    8'h30: begin
                        tx_data_d = {216'b0, err_cnt_q, 24'(addr_q), STATUS_MAGIC};
                        state_d   = S_TX_WAIT;
                    end
                    default: begin
                        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                    end
                endcase
            end
            S_FETCH: begin
                if (!issue_k_q[5]) begin
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = addr_q + ADDR_W'(issue_k_q);
                    issue_k_d   = issue_k_q + 6'd1;
                end
                // Read data is valid the cycle after the strobe, so capture trails issue by one.
                rd_pend_d = mem_rd_en_q;
                if (rd_pend_q) begin
                    tx_data_d[{cap_k_q, 3'b000} +: 8] = mem_rd_data;
                    cap_k_d = cap_k_q + 5'd1;
                    if (cap_k_q == 5'd31) begin
                        addr_d = addr_q + ADDR_W'(32);
                        if (tx_free) begin
                            tx_en_d = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_TX_WAIT;
                        end
                    end
                end
            end
            S_TX_WAIT: begin
                if (tx_free) begin
                    tx_en_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_REG_WAIT: begin
                if (!reg_busy) begin
                    reg_req_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            cmd_seen_q  <= 1'b0;
            addr_q      <= '0;
            err_cnt_q   <= '0;
            issue_k_q   <= '0;
            cap_k_q     <= '0;
            rd_pend_q   <= 1'b0;
            cmd_ack_q   <= 1'b0;
            tx_en_q     <= 1'b0;
            tx_data_q   <= '0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            reg_req_q   <= 1'b0;
            reg_addr_q  <= '0;
            reg_val_q   <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            cmd_seen_q  <= cmd_seen_d;
            addr_q      <= addr_d;
            err_cnt_q   <= err_cnt_d;
            issue_k_q   <= issue_k_d;
            cap_k_q     <= cap_k_d;
            rd_pend_q   <= rd_pend_d;
            cmd_ack_q   <= cmd_ack_d;
            tx_en_q     <= tx_en_d;
            tx_data_q   <= tx_data_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_addr_q  <= mem_addr_d;
            reg_req_q   <= reg_req_d;
            reg_addr_q  <= reg_addr_d;
            reg_val_q   <= reg_val_d;
        end
    end

    assign cmd_ack   = cmd_ack_q;
    assign tx_en     = tx_en_q;
    assign tx_data   = tx_data_q;
    assign mem_rd_en = mem_rd_en_q;
    assign mem_addr  = mem_addr_q;
    assign reg_req   = reg_req_q;
    assign reg_addr  = reg_addr_q;
    assign reg_val   = reg_val_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Bench for spi_cmd_ctrl: directed commands push expected replies, memory strobes and
// register writes into queues; a negedge monitor pops and compares as the DUT produces them.
module tb_spi_cmd_ctrl;
  localparam int ADDR_W = 17;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              cmd_valid = 1'b0;
  logic [31:0]       cmd_data = '0;
  logic              cmd_ack;
  logic              tx_free = 1'b1;
  logic              tx_en;
  logic [255:0]      tx_data;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rd_data = '0;
  logic              reg_busy = 1'b0;
  logic              reg_req;
  logic [7:0]        reg_addr;
  logic [7:0]        reg_val;
  logic [2:0]        dbg_state;

  spi_cmd_ctrl #(.ADDR_W(ADDR_W), .STATUS_MAGIC(8'h5A)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ack(cmd_ack),
    .tx_free(tx_free), .tx_en(tx_en), .tx_data(tx_data),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .reg_busy(reg_busy), .reg_req(reg_req), .reg_addr(reg_addr), .reg_val(reg_val),
    .dbg_state(dbg_state)
  );

  // clock / reset-sample / memory model
  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_s = 1'b0;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_s <= reset;
  end

  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem_addr[7:0];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int errors = 0;
  int checks = 0;
  logic [255:0]      exp_tx_q[$];
  int                exp_tx_cyc_q[$];
  logic [15:0]       exp_reg_q[$];
  int                exp_reg_cyc_q[$];
  logic [ADDR_W-1:0] exp_mem_q[$];
  int                exp_mem_cyc_q[$];
  int ack_cnt = 0;
  int tx_cnt = 0;
  int req_cnt = 0;

  logic [ADDR_W-1:0] m_addr = '0;
  logic [7:0]        m_err = '0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [255:0]      mon_tx;
  logic [15:0]       mon_reg;
  logic [ADDR_W-1:0] mon_mem;
  int                mon_c;

  always @(negedge clk) begin
    if (!rst_s) begin
      chk("reset_outputs", 256'({cmd_ack, tx_en, mem_rd_en, reg_req, |tx_data, |mem_addr,
                                 |reg_addr, |reg_val, dbg_state}), 256'(0));
    end else begin
      if (cmd_ack) ack_cnt++;
      if (tx_en) begin
        tx_cnt++;
        chk("tx_expected", 256'(exp_tx_q.size() > 0), 256'(1));
        if (exp_tx_q.size() > 0) begin
          mon_tx = exp_tx_q.pop_front();
          mon_c  = exp_tx_cyc_q.pop_front();
          chk("tx_data", tx_data, mon_tx);
          if (mon_c >= 0) chk("tx_cycle", 256'(cyc), 256'(mon_c));
        end
      end
      if (reg_req) begin
        req_cnt++;
        chk("reg_expected", 256'(exp_reg_q.size() > 0), 256'(1));
        if (exp_reg_q.size() > 0) begin
          mon_reg = exp_reg_q.pop_front();
          mon_c   = exp_reg_cyc_q.pop_front();
          chk("reg_addr_val", 256'({reg_addr, reg_val}), 256'(mon_reg));
          if (mon_c >= 0) chk("reg_cycle", 256'(cyc), 256'(mon_c));
        end
      end
      if (mem_rd_en) begin
        chk("mem_expected", 256'(exp_mem_q.size() > 0), 256'(1));
        if (exp_mem_q.size() > 0) begin
          mon_mem = exp_mem_q.pop_front();
          mon_c   = exp_mem_cyc_q.pop_front();
          chk("mem_addr", 256'(mem_addr), 256'(mon_mem));
          chk("mem_cycle", 256'(cyc), 256'(mon_c));
        end
      end
    end
  end

  // driver tasks
  task automatic issue_cmd(input logic [7:0] op, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, output int a);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = {b2, b1, b0, op};
    a = -1;
    for (int n = 0; n < 300 && a < 0; n++) begin
      @(negedge clk);
      if (cmd_ack) a = cyc;
    end
    chk("cmd_ack_seen", 256'(a >= 0), 256'(1));
  endtask

  task automatic release_cmd(input int hold);
    repeat (hold) @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic cmd_status(input int hold);
    int a;
    issue_cmd(8'h30, 8'h00, 8'h00, 8'h00, a);
    exp_tx_q.push_back({216'b0, m_err, 24'(m_addr), 8'h5A});
    exp_tx_cyc_q.push_back(a + 2);
    release_cmd(hold);
  endtask

  task automatic cmd_set_addr(input logic [23:0] v);
    int a;
    issue_cmd(8'h10, v[7:0], v[15:8], v[23:16], a);
    m_addr = v[ADDR_W-1:0];
    release_cmd(0);
  endtask

  task automatic cmd_read(input bit timed);
    int a;
    logic [255:0]      w;
    logic [ADDR_W-1:0] t;
    issue_cmd(8'h11, 8'h00, 8'h00, 8'h00, a);
    w = '0;
    for (int k = 0; k < 32; k++) begin
      t = m_addr + ADDR_W'(k);
      exp_mem_q.push_back(t);
      exp_mem_cyc_q.push_back(a + 2 + k);
      w[8*k +: 8] = t[7:0];
    end
    exp_tx_q.push_back(w);
    exp_tx_cyc_q.push_back(timed ? a + 35 : -1);
    m_addr = m_addr + ADDR_W'(32);
    release_cmd(0);
  endtask

  task automatic drain();
    for (int n = 0; n < 400 && (exp_tx_q.size() + exp_reg_q.size() + exp_mem_q.size()) > 0; n++)
      @(negedge clk);
    repeat (2) @(negedge clk);
    chk("queues_drained", 256'(exp_tx_q.size() + exp_reg_q.size() + exp_mem_q.size()), 256'(0));
  endtask

  // directed tests
  initial begin
    int a;
    int base;
    int base2;

    // T1: reset then STATUS
    repeat (3) @(negedge clk);
    reset = 1'b1;
    cmd_status(0);
    drain();

    // T2: block read from 0x100, then STATUS shows 0x120
    cmd_set_addr(24'h000100);
    cmd_read(1'b1);
    cmd_status(0);
    drain();

    // T3: block read wrapping past the top of the address space
    cmd_set_addr(24'h01FFF0);
    cmd_read(1'b1);
    cmd_status(0);
    drain();

    // T4: register write held off by reg_busy, then an unblocked one
    reg_busy = 1'b1;
    base = req_cnt;
    issue_cmd(8'h20, 8'h12, 8'h80, 8'h00, a);
    release_cmd(0);
    repeat (10) @(negedge clk);
    chk("reg_req_while_busy", 256'(req_cnt), 256'(base));
    exp_reg_q.push_back(16'h1280);
    exp_reg_cyc_q.push_back(cyc + 1);
    reg_busy = 1'b0;
    drain();
    chk("reg_req_single", 256'(req_cnt), 256'(base + 1));
    issue_cmd(8'h20, 8'h34, 8'h56, 8'h00, a);
    exp_reg_q.push_back(16'h3456);
    exp_reg_cyc_q.push_back(a + 2);
    release_cmd(0);
    drain();
    chk("reg_held", 256'({reg_addr, reg_val}), 256'(16'h3456));

    // T5a: cmd_valid held long after ack -> consumed once
    base  = ack_cnt;
    base2 = tx_cnt;
    cmd_status(20);
    drain();
    chk("single_ack", 256'(ack_cnt), 256'(base + 1));
    chk("single_tx_status", 256'(tx_cnt), 256'(base2 + 1));

    // T5b: tx_free low stalls the reply
    tx_free = 1'b0;
    base = tx_cnt;
    cmd_read(1'b0);
    repeat (50) @(negedge clk);
    chk("tx_held_off", 256'(tx_cnt), 256'(base));
    chk("stall_state", 256'(dbg_state), 256'(3));
    tx_free = 1'b1;
    drain();
    chk("tx_after_free", 256'(tx_cnt), 256'(base + 1));

    // NOP / INIT change nothing; STATUS confirms
    issue_cmd(8'h00, 8'hAA, 8'hBB, 8'hCC, a);
    release_cmd(0);
    issue_cmd(8'h01, 8'hAA, 8'hBB, 8'hCC, a);
    release_cmd(0);
    cmd_status(0);
    drain();

    // T6: error counter saturates
    for (int i = 0; i < 300; i++) begin
      issue_cmd(8'hEE, 8'h00, 8'h00, 8'h00, a);
      release_cmd(0);
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
    end
    cmd_status(0);
    drain();

    // T6: reset in the middle of a block fetch
    base = tx_cnt;
    cmd_read(1'b1);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    exp_tx_q.delete();
    exp_tx_cyc_q.delete();
    exp_mem_q.delete();
    exp_mem_cyc_q.delete();
    m_addr = '0;
    m_err  = '0;
    chk("reset_state_idle", 256'(dbg_state), 256'(0));
    reset = 1'b1;
    repeat (60) @(negedge clk);
    chk("no_tx_after_reset", 256'(tx_cnt), 256'(base));
    chk("no_mem_after_reset", 256'(mem_rd_en), 256'(0));
    cmd_status(0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
